// File: rtl/pipe_pkg.sv
//==============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the CPU pipeline register stages.
// Revision    : 1.0
//==============================================================================
`default_nettype none

package pipe_pkg;

    localparam int          INSTR_W_DEF   = 32;
    localparam int          PC_W_DEF      = 32;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    // Number of held entries for a given stage state.
    function automatic logic [1:0] occ_of(input pipe_state_t s);
        case (s)
            ONE:     occ_of = 2'd1;
            FULL:    occ_of = 2'd2;
            default: occ_of = 2'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_skid.sv
//==============================================================================
// Module      : if_id_skid
// Description : IF/ID pipeline register with two-entry skid buffer and flush.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module if_id_skid
    import pipe_pkg::*;
#(
    parameter int                 INSTR_W   = INSTR_W_DEF,
    parameter int                 PC_W      = PC_W_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_npc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_npc,
    output logic [1:0]         occupancy
);

    pipe_state_t        r_state;
    pipe_state_t        w_state_nxt;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [PC_W-1:0]    r_skid_npc;
    logic               w_in_fire;
    logic               w_out_fire;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: if (w_in_fire) w_state_nxt = ONE;
            ONE: begin
                if (w_in_fire && !w_out_fire)      w_state_nxt = FULL;
                else if (!w_in_fire && w_out_fire) w_state_nxt = EMPTY;
            end
            FULL:    if (w_out_fire) w_state_nxt = ONE;
            default: w_state_nxt = EMPTY;
        endcase
    end

    // Handshake flags are registered from the next state so that in_ready
    // never depends combinationally on out_ready.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state   <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_instr <= NOP_INSTR;
            out_npc   <= '0;
            occupancy <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            in_ready  <= (w_state_nxt != FULL);
            out_valid <= (w_state_nxt != EMPTY);
            occupancy <= occ_of(w_state_nxt);
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        out_instr <= in_instr;
                        out_npc   <= in_npc;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        out_instr <= in_instr;
                        out_npc   <= in_npc;
                    end else if (w_in_fire) begin
                        r_skid_instr <= in_instr;
                        r_skid_npc   <= in_npc;
                    end else if (w_out_fire) begin
                        out_instr <= NOP_INSTR;
                        out_npc   <= '0;
                    end
                end
                FULL: begin
                    if (w_out_fire) begin
                        out_instr <= r_skid_instr;
                        out_npc   <= r_skid_npc;
                    end
                end
                default: begin
                    out_instr <= NOP_INSTR;
                    out_npc   <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
